// File: rtl/uart8n1_tx_hs_if.sv
// Byte handshake between a producer and the uart8n1_tx_hs transmitter.
// A byte moves on the rising edge where txValid && txReady.
interface uart8n1_tx_hs_if;

   logic [7:0] txByte;
   logic       txValid;
   logic       txReady;

   // Producer side
   modport master (
      output txByte,
      output txValid,
      input  txReady
   );

   // Transmitter side
   modport slave (
      input  txByte,
      input  txValid,
      output txReady
   );

endinterface : uart8n1_tx_hs_if

// File: rtl/uart8n1_tx_hs.sv
// UART 8N1 transmitter with an internal baud divider and a valid/ready byte
// handshake; everything runs on hwclk, no separate baud clock domain.
// Optional feature: define UART_TX_PARITY_EN to insert a parity bit between
// D7 and the stop bit(s) (even parity, odd when PARITY_ODD=1). Without the
// macro the frame is plain 8N1 and PARITY_ODD only takes part in the
// configuration check.
module uart8n1_tx_hs #(
   parameter int unsigned CLKS_PER_BIT = 1250,
   parameter int unsigned STOP_BITS    = 1,
   parameter int unsigned PARITY_ODD   = 0
) (
   input  logic           hwclk,
   input  logic           rst,
   uart8n1_tx_hs_if.slave hs,
   output logic           tx,
   output logic           busy,
   output logic           txDone
);

   localparam int unsigned BAUD_W = 16;
   localparam int unsigned BIT_W  = 3;

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
   localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(7);
   localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
   localparam logic PAR_INV = 1'(PARITY_ODD);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_STOP  = 3'd3
   } state_t;
`endif

   // Elaboration-time rejection of illegal configurations
   if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535 ||
       !(STOP_BITS == 1 || STOP_BITS == 2) || PARITY_ODD > 1) begin : g_cfg_err
      $error("uart8n1_tx_hs: illegal configuration CLKS_PER_BIT=%0d STOP_BITS=%0d PARITY_ODD=%0d",
             CLKS_PER_BIT, STOP_BITS, PARITY_ODD);
   end

   state_t             r_state;
   state_t             w_state_nxt;
   logic [BAUD_W-1:0]  r_baud;
   logic [BAUD_W-1:0]  w_baud_nxt;
   logic [BIT_W-1:0]   r_bit;
   logic [BIT_W-1:0]   w_bit_nxt;
   logic [7:0]         r_shift;
   logic [7:0]         w_shift_nxt;
   logic               r_tx;
   logic               w_tx_nxt;
   logic               r_ready;
   logic               w_ready_nxt;
   logic               r_busy;
   logic               w_busy_nxt;
   logic               r_done;
   logic               w_done_nxt;
   logic               w_bit_end;
   logic               w_accept;
`ifdef UART_TX_PARITY_EN
   logic               r_par;
   logic               w_par_nxt;
`endif

   assign w_bit_end = (r_baud == BAUD_LAST);
   assign w_accept  = hs.txValid && r_ready;

   assign hs.txReady = r_ready;
   assign tx         = r_tx;
   assign busy       = r_busy;
   assign txDone     = r_done;

   // Next-state and next-output logic; every output is registered one stage
   always_comb begin
      w_state_nxt = r_state;
      w_baud_nxt  = r_baud + BAUD_W'(1);
      w_bit_nxt   = r_bit;
      w_shift_nxt = r_shift;
      w_tx_nxt    = r_tx;
      w_ready_nxt = r_ready;
      w_busy_nxt  = r_busy;
      w_done_nxt  = 1'b0;
`ifdef UART_TX_PARITY_EN
      w_par_nxt   = r_par;
`endif

      unique case (r_state)
         S_IDLE: begin
            w_baud_nxt  = '0;
            w_bit_nxt   = '0;
            w_tx_nxt    = 1'b1;
            w_ready_nxt = 1'b1;
            w_busy_nxt  = 1'b0;
            if (w_accept) begin
               w_state_nxt = S_START;
               w_shift_nxt = hs.txByte;
`ifdef UART_TX_PARITY_EN
               w_par_nxt   = (^hs.txByte) ^ PAR_INV;
`endif
               w_tx_nxt    = 1'b0;
               w_ready_nxt = 1'b0;
               w_busy_nxt  = 1'b1;
            end
         end

         S_START: begin
            if (w_bit_end) begin
               w_baud_nxt  = '0;
               w_state_nxt = S_DATA;
               w_tx_nxt    = r_shift[0];
            end
         end

         S_DATA: begin
            if (w_bit_end) begin
               w_baud_nxt = '0;
               if (r_bit == DATA_LAST) begin
                  w_bit_nxt   = '0;
`ifdef UART_TX_PARITY_EN
                  w_state_nxt = S_PARITY;
                  w_tx_nxt    = r_par;
`else
                  w_state_nxt = S_STOP;
                  w_tx_nxt    = 1'b1;
`endif
               end else begin
                  w_bit_nxt   = r_bit + BIT_W'(1);
                  w_shift_nxt = {1'b0, r_shift[7:1]};
                  w_tx_nxt    = r_shift[1];
               end
            end
         end

`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (w_bit_end) begin
               w_baud_nxt  = '0;
               w_state_nxt = S_STOP;
               w_tx_nxt    = 1'b1;
            end
         end
`endif

         S_STOP: begin
            // txDone is registered, so raise it one cycle early to land on the final stop cycle
            if (r_baud == BAUD_PRE && r_bit == STOP_LAST) begin
               w_done_nxt = 1'b1;
            end
            if (w_bit_end) begin
               w_baud_nxt = '0;
               if (r_bit == STOP_LAST) begin
                  w_state_nxt = S_IDLE;
                  w_bit_nxt   = '0;
                  w_tx_nxt    = 1'b1;
                  w_ready_nxt = 1'b1;
                  w_busy_nxt  = 1'b0;
               end else begin
                  w_bit_nxt = r_bit + BIT_W'(1);
               end
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
            w_baud_nxt  = '0;
            w_bit_nxt   = '0;
            w_tx_nxt    = 1'b1;
            w_ready_nxt = 1'b1;
            w_busy_nxt  = 1'b0;
         end
      endcase
   end

   // State, counters, shift register and output registers with synchronous reset
   always_ff @(posedge hwclk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_baud  <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_tx    <= 1'b1;
         r_ready <= 1'b1;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
         r_par   <= 1'b0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_baud  <= w_baud_nxt;
         r_bit   <= w_bit_nxt;
         r_shift <= w_shift_nxt;
         r_tx    <= w_tx_nxt;
         r_ready <= w_ready_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
`ifdef UART_TX_PARITY_EN
         r_par   <= w_par_nxt;
`endif
      end
   end

endmodule : uart8n1_tx_hs

// File: tb/tb_uart8n1_tx_hs.sv
// Self-checking bench for uart8n1_tx_hs with CLKS_PER_BIT=4.
// A line receiver decodes every frame and compares it against a queue of
// bytes pushed at handshake time; scenario tasks check cycle-exact timing.
module tb_uart8n1_tx_hs;

   localparam int N             = 4;
   localparam int TB_PARITY_ODD = 0;
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   localparam int FRAME = NB * N;

   logic hwclk = 1'b0;
   logic rst   = 1'b1;
   logic tx;
   logic busy;
   logic txDone;

   int total = 0;
   int bad   = 0;

   logic [7:0] exp_q[$];

   uart8n1_tx_hs_if hs_if ();

   uart8n1_tx_hs #(
      .CLKS_PER_BIT (N),
      .STOP_BITS    (1),
      .PARITY_ODD   (TB_PARITY_ODD)
   ) dut (
      .hwclk  (hwclk),
      .rst    (rst),
      .hs     (hs_if),
      .tx     (tx),
      .busy   (busy),
      .txDone (txDone)
   );

   always #5 hwclk = ~hwclk;

   // Watchdog so the run always terminates
   initial begin
      #200000;
      $display("FAIL watchdog expired got=timeout want=finish");
      $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
      $fatal(1, "watchdog");
   end

   // Line receiver: samples mid-bit on the falling edge, pops the scoreboard at the stop bit
   logic       mon_active = 1'b0;
   int         mon_cnt    = 0;
   int         mon_idx    = 0;
   logic [7:0] mon_byte   = '0;
   logic [7:0] mon_exp    = '0;

   always @(negedge hwclk) begin
      if (rst) begin
         mon_active = 1'b0;
      end else if (!mon_active) begin
         if (tx === 1'b0) begin
            mon_active = 1'b1;
            mon_cnt    = 0;
            mon_byte   = '0;
         end
      end else begin
         mon_cnt = mon_cnt + 1;
         if (mon_cnt % N == N / 2) begin
            mon_idx = mon_cnt / N;
            if (mon_idx == 0) begin
               total++;
               if (tx !== 1'b0) begin
                  bad++;
                  $display("FAIL rx_start got=%b want=0", tx);
               end
            end else if (mon_idx <= 8) begin
               mon_byte[3'(mon_idx - 1)] = tx;
`ifdef UART_TX_PARITY_EN
            end else if (mon_idx == 9) begin
               total++;
               if (tx !== ((^mon_byte) ^ 1'(TB_PARITY_ODD))) begin
                  bad++;
                  $display("FAIL rx_parity byte=%02h got=%b want=%b", mon_byte, tx,
                           (^mon_byte) ^ 1'(TB_PARITY_ODD));
               end
`endif
            end else begin
               total++;
               if (tx !== 1'b1) begin
                  bad++;
                  $display("FAIL rx_stop got=%b want=1", tx);
               end
               total++;
               if (exp_q.size() == 0) begin
                  bad++;
                  $display("FAIL rx_unexpected_frame got=%02h want=none", mon_byte);
               end else begin
                  mon_exp = exp_q.pop_front();
                  if (mon_byte !== mon_exp) begin
                     bad++;
                     $display("FAIL rx_byte got=%02h want=%02h", mon_byte, mon_exp);
                  end
               end
               mon_active = 1'b0;
            end
         end
      end
   end

   task automatic tick();
      @(posedge hwclk);
      #1;
   endtask

   // Expected line level at offset k (1-based) after the handshake edge
   function automatic logic exp_line(input logic [7:0] b, input int k);
      int idx;
      idx = (k - 1) / N;
      if (idx == 0) return 1'b0;
      if (idx <= 8) return b[3'(idx - 1)];
`ifdef UART_TX_PARITY_EN
      if (idx == 9) return (^b) ^ 1'(TB_PARITY_ODD);
`endif
      return 1'b1;
   endfunction

   // Present a byte, wait (bounded) for txReady, complete the handshake edge
   task automatic send(input logic [7:0] b, input bit hold);
      int guard;
      guard = 0;
      hs_if.txByte  = b;
      hs_if.txValid = 1'b1;
      while (hs_if.txReady !== 1'b1 && guard < 200) begin
         tick();
         guard++;
      end
      total++;
      if (guard >= 200) begin
         bad++;
         $display("FAIL send_timeout got=ready_%b want=ready_1", hs_if.txReady);
         hs_if.txValid = 1'b0;
      end else begin
         tick();
         exp_q.push_back(b);
         if (!hold) hs_if.txValid = 1'b0;
      end
   endtask

   task automatic test_reset();
      logic [3:0] obs;
      hs_if.txByte  = 8'h00;
      hs_if.txValid = 1'b0;
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      for (int i = 0; i < 50; i++) begin
         obs = {tx, hs_if.txReady, busy, txDone};
         total++;
         if (obs !== 4'b1100) begin
            bad++;
            $display("FAIL reset_idle cyc=%0d got=%b want=1100", i, obs);
         end
         tick();
      end
   endtask

   task automatic test_frame(input logic [7:0] b);
      logic [3:0] obs;
      logic [3:0] exp;
      send(b, 1'b0);
      for (int k = 1; k <= FRAME; k++) begin
         obs = {tx, hs_if.txReady, busy, txDone};
         exp = {exp_line(b, k), 1'b0, 1'b1, (k == FRAME) ? 1'b1 : 1'b0};
         total++;
         if (obs !== exp) begin
            bad++;
            $display("FAIL frame_%02h k=%0d got=%b want=%b", b, k, obs, exp);
         end
         tick();
      end
      obs = {tx, hs_if.txReady, busy, txDone};
      total++;
      if (obs !== 4'b1100) begin
         bad++;
         $display("FAIL frame_end_%02h got=%b want=1100", b, obs);
      end
   endtask

   task automatic test_back_to_back();
      logic [1:0] obs2;
      logic [2:0] obs3;
      send(8'h55, 1'b1);
      hs_if.txByte = 8'hAA;
      repeat (FRAME) tick();
      obs2 = {tx, hs_if.txReady};
      total++;
      if (obs2 !== 2'b11) begin
         bad++;
         $display("FAIL b2b_gap got=%b want=11", obs2);
      end
      tick();
      exp_q.push_back(8'hAA);
      hs_if.txValid = 1'b0;
      obs3 = {tx, hs_if.txReady, busy};
      total++;
      if (obs3 !== 3'b001) begin
         bad++;
         $display("FAIL b2b_second_start got=%b want=001", obs3);
      end
      repeat (FRAME + 5) tick();
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL b2b_drain got=%0d want=0", exp_q.size());
      end
   endtask

   task automatic test_ignore_change();
      logic [3:0] obs;
      send(8'h00, 1'b0);
      repeat (10) tick();
      hs_if.txByte  = 8'hFF;
      hs_if.txValid = 1'b1;
      tick();
      hs_if.txValid = 1'b0;
      repeat (FRAME) tick();
      for (int i = 0; i < 50; i++) begin
         obs = {tx, hs_if.txReady, busy, txDone};
         total++;
         if (obs !== 4'b1100) begin
            bad++;
            $display("FAIL ignore_idle cyc=%0d got=%b want=1100", i, obs);
         end
         tick();
      end
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL ignore_drain got=%0d want=0", exp_q.size());
      end
   endtask

   task automatic test_reset_mid();
      logic [3:0] obs;
      send(8'h52, 1'b0);
      repeat (17) tick();
      total++;
      if (tx !== 1'b0) begin
         bad++;
         $display("FAIL rstmid_d3 got=%b want=0", tx);
      end
      rst = 1'b1;
      void'(exp_q.pop_back());
      tick();
      rst = 1'b0;
      obs = {tx, hs_if.txReady, busy, txDone};
      total++;
      if (obs !== 4'b1100) begin
         bad++;
         $display("FAIL rstmid_after got=%b want=1100", obs);
      end
      for (int i = 0; i < 2 * FRAME; i++) begin
         tick();
         obs = {tx, hs_if.txReady, busy, txDone};
         total++;
         if (obs !== 4'b1100) begin
            bad++;
            $display("FAIL rstmid_quiet cyc=%0d got=%b want=1100", i, obs);
         end
      end
      send(8'h41, 1'b0);
      repeat (FRAME + 2) tick();
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL rstmid_resend got=%0d want=0", exp_q.size());
      end
   endtask

   task automatic test_reset_valid();
      logic [3:0] obs;
      hs_if.txByte  = 8'h3C;
      hs_if.txValid = 1'b1;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      hs_if.txValid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         obs = {tx, hs_if.txReady, busy, txDone};
         total++;
         if (obs !== 4'b1100) begin
            bad++;
            $display("FAIL rst_valid cyc=%0d got=%b want=1100", i, obs);
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_frame(8'h30);
      test_frame(8'h07);
      test_back_to_back();
      test_ignore_change();
      test_reset_mid();
      test_reset_valid();
      repeat (FRAME) tick();
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL final_drain got=%0d want=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_uart8n1_tx_hs
